vga_pixel_out: RTL and testbench
================================

# vga_pixel_out

Downstream stage of the dithering block. Generates 1024×768@60 Hz VGA timing from free-running horizontal and vertical counters and publishes the current pixel coordinate to the upstream fetch/dither path. It accepts the resulting 24-bit dithered pixel and drives the 12-bit VGA DAC pins. Sync, blanking and colour are aligned through a parameterised delay line, so upstream latency never skews the image.

## Interface
- H_VISIBLE, 1024, active pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_VISIBLE, 768, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- PIPE_LAT, 1, upstream latency in clocks, from hc/vc valid to matching pixel_in valid (0..4)
- clk  in  1  pixel clock, 65 MHz
- reset_n  in  1  synchronous reset, active low
- pixel_in  in  24  dithered pixel {R[7:0],G[7:0],B[7:0]} for the coordinate issued PIPE_LAT clocks earlier
- hc  out  11  current horizontal count, 0..H_TOTAL-1
- vc  out  10  current vertical count, 0..V_TOTAL-1
- visible  out  1  hc<H_VISIBLE && vc<V_VISIBLE, undelayed
- frame_start  out  1  one-clock pulse while hc==0 && vc==0
- vga_r, vga_g, vga_b  out  4 each  DAC colour, registered
- vga_hs, vga_vs  out  1 each  syncs, active low, registered

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (806).
- hc increments every clock and wraps H_TOTAL-1→0. On that wrap, vc increments and wraps V_TOTAL-1→0. No other state; counters never stall.
- Raw hsync is low for hc in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. 1048..1183. Raw vsync is low for vc in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. 771..776. Both are combinational decodes of hc/vc.
- Delay line: raw hsync, vsync and visible pass through a PIPE_LAT-deep shift register. The output register then captures the delayed values together with pixel_in.
- Colour: when delayed visible=1, vga_r=pixel_in[23:20], vga_g=pixel_in[15:12], vga_b=pixel_in[7:4]. Otherwise all colour bits are 0 (blanking is mandatory). The lower nibbles are discarded; upstream dithering already rounded them.
- Reset (reset_n=0 at a clk edge):
  - hc=0, vc=0.
  - Delay-line entries become visible=0, hsync=1, vsync=1.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1.
  - Reset asserted mid-line or mid-frame restarts at (0,0) on the next edge, with no partial sync pulse carried over.
- frame_start, visible, hc and vc reflect the registered counters. They are valid in the first cycle after reset release: frame_start=1, visible=1.

## Timing
- Counter-to-pin latency D = PIPE_LAT+1 clocks. Pins in cycle t reflect hc/vc of cycle t−D.
- Default PIPE_LAT=1: first cycle after reset release is t=0 (hc=0). The first vga_hs low is at t=1050 and lasts exactly 136 clocks. First vga_vs low is at line 771 and lasts 6×1344 clocks.
- Line period 1344 clocks; frame period 1,083,264 clocks. frame_start recurs exactly once per frame.
- Transitions on vga_hs, vga_vs and colour occur only on clk edges; all are glitch-free registered outputs.
- During the first D cycles after reset, pins hold reset values (hsync high, colour 0).

## Structure
- Package vga_pkg:
  - timing localparams H_TOTAL and V_TOTAL, plus default porch/sync constants;
  - typedef pixel24_t, a packed struct {r,g,b} of 8 bits each;
  - typedef rgb12_t, 4 bits each.
- Sub-module vga_timing holds the counters and the hsync/vsync/visible/frame_start decode.
- vga_pixel_out instantiates vga_timing plus the delay line and output register.

## Test plan
- Reset held 5 clocks, released:
  - hc=0, vc=0, frame_start=1 in cycle 0;
  - vga_hs=1 and vga_r/g/b=0 in cycles 0..1;
  - first vga_hs fall at cycle 1050, rise at 1186.
- Run one full frame: frame_start pulses at cycles 0 and 1,083,264 only; vga_vs low for exactly 8064 clocks starting at line 771.
- Drive pixel_in = 24'hF8A050 during the visible region: pins show r=F, g=A, b=5. During hc≥1024 or vc≥768 with the same input, pins show 0,0,0.
- PIPE_LAT=3, upstream model returns pixel_in={hc[7:0],vc[7:0],8'h00} three clocks late: pin colour for visible pixel (hc=0x35,vc=0x12) shows r=3, g=1, matching exactly the cycle where delayed visible=1 and hsync alignment is D=4.
- Assert reset_n=0 at hc=500, vc=300 for one clock: next cycle hc=0, vc=0, vga_hs=1, vga_vs=1, colour 0; normal timing resumes from frame start.
- Counter wrap: at hc=1343, vc=805, next clock gives hc=0, vc=0, frame_start=1; at hc=1343, vc=10, next gives vc=11.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel types for the pixel-output slice.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 1024;
  localparam int DEF_H_FP      = 24;
  localparam int DEF_H_SYNC    = 136;
  localparam int DEF_H_BP      = 160;
  localparam int DEF_V_VISIBLE = 768;
  localparam int DEF_V_FP      = 3;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 29;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel24_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // Upstream dithering already rounded, so the top nibble is taken as-is.
  function automatic rgb12_t to_rgb12(input pixel24_t p, input logic en);
    rgb12_t c;
    c = '0;
    if (en) begin
      c.r = p.r[7:4];
      c.g = p.g[7:4];
      c.b = p.b[7:4];
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_pixel_out_if.sv
// Coordinate/pixel exchange between the VGA output stage and the fetch/dither path.
interface vga_pixel_out_if;
  import vga_pkg::*;

  logic [10:0] hc;
  logic [9:0]  vc;
  logic        visible;
  logic        frame_start;
  pixel24_t    pixel_in;

  modport master (output hc, output vc, output visible, output frame_start, input pixel_in);
  modport slave  (input hc, input vc, input visible, input frame_start, output pixel_in);

endinterface

// File: rtl/vga_timing.sv
// Free-running horizontal/vertical counters with raw sync, visible and frame decode.
module vga_timing #(
  parameter int H_VISIBLE = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_VISIBLE = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] hc,
  output logic [9:0]  vc,
  output logic        visible,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync
);

  localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
    end else begin
      hc <= hc + 11'd1;
    end
  end

  // Syncs are active low and decoded straight from the registered counters.
  always_comb begin
    visible     = (hc < H_VIS) && (vc < V_VIS);
    frame_start = (hc == '0) && (vc == '0);
    hsync       = !((hc >= HS_START) && (hc < HS_END));
    vsync       = !((vc >= VS_START) && (vc < VS_END));
  end

endmodule

// File: rtl/vga_pixel_out.sv
// VGA output stage: timing generator, sync delay line matching upstream latency, registered DAC pins.
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int PIPE_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vga_pixel_out_if.master        pix,
  output logic [3:0]             vga_r,
  output logic [3:0]             vga_g,
  output logic [3:0]             vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs
);

  sync_t  ctrl_p0;
  sync_t  ctrl_pd;
  rgb12_t rgb_pd;

  vga_timing #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .hc          (pix.hc),
    .vc          (pix.vc),
    .visible     (ctrl_p0.visible),
    .frame_start (pix.frame_start),
    .hsync       (ctrl_p0.hsync),
    .vsync       (ctrl_p0.vsync)
  );

  assign pix.visible = ctrl_p0.visible;

  // Delay line: syncs and visible wait PIPE_LAT clocks for the matching pixel.
  generate
    if (PIPE_LAT == 0) begin : g_no_delay
      assign ctrl_pd = ctrl_p0;
    end else begin : g_delay
      sync_t ctrl_pipe [PIPE_LAT];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            ctrl_pipe[i] <= SYNC_IDLE;
          end
        end else begin
          ctrl_pipe[0] <= ctrl_p0;
          for (int i = 1; i < PIPE_LAT; i++) begin
            ctrl_pipe[i] <= ctrl_pipe[i-1];
          end
        end
      end

      assign ctrl_pd = ctrl_pipe[PIPE_LAT-1];
    end
  endgenerate

  always_comb begin
    rgb_pd = to_rgb12(pix.pixel_in, ctrl_pd.visible);
  end

  // Output register: every pin changes only on a clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= rgb_pd.r;
      vga_g  <= rgb_pd.g;
      vga_b  <= rgb_pd.b;
      vga_hs <= ctrl_pd.hsync;
      vga_vs <= ctrl_pd.vsync;
    end
  end

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench: default 1024x768 instance plus a shrunken-timing PIPE_LAT=3 instance.
module tb_vga_pixel_out;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, hs_b, vs_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_pixel_out_if bus_a ();
  vga_pixel_out_if bus_b ();

  vga_pixel_out dut_a (
    .clk     (clk),
    .reset_n (rst_a_n),
    .pix     (bus_a),
    .vga_r   (r_a),
    .vga_g   (g_a),
    .vga_b   (b_a),
    .vga_hs  (hs_a),
    .vga_vs  (vs_a)
  );

  // Small frame: 80 clocks/line (sync at 68..75), 32 lines/frame (sync at 26..28).
  vga_pixel_out #(
    .H_VISIBLE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_VISIBLE (24), .V_FP (2), .V_SYNC (3), .V_BP (3),
    .PIPE_LAT  (3)
  ) dut_b (
    .clk     (clk),
    .reset_n (rst_b_n),
    .pix     (bus_b),
    .vga_r   (r_b),
    .vga_g   (g_b),
    .vga_b   (b_b),
    .vga_hs  (hs_b),
    .vga_vs  (vs_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [15:0] hist [4];
    int fs_a_cnt = 0;
    int fs_b_cnt = 0;
    int hs_a_low = 0;
    int vs_b_low = 0;
    logic [11:0] rgb_a, rgb_b;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    bus_a.pixel_in = 24'hF8A050;
    bus_b.pixel_in = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    for (int t = 0; t <= 14800; t++) begin
      if (t > 0) @(negedge clk);
      rgb_a = {r_a, g_a, b_a};
      rgb_b = {r_b, g_b, b_b};
      if (bus_a.frame_start) fs_a_cnt++;
      if (bus_b.frame_start && t < 4210) fs_b_cnt++;
      if (!hs_a && t < 1344) hs_a_low++;
      if (!vs_b && t < 2560) vs_b_low++;

      // Default instance, PIPE_LAT=1
      if (t == 0) begin
        check_val("a_rst_hc", 32'(bus_a.hc), 0);
        check_val("a_rst_vc", 32'(bus_a.vc), 0);
        check_val("a_rst_fs", 32'(bus_a.frame_start), 1);
        check_val("a_rst_vis", 32'(bus_a.visible), 1);
        check_val("a_rst_hs", 32'(hs_a), 1);
        check_val("a_rst_vs", 32'(vs_a), 1);
        check_val("a_rst_rgb0", 32'(rgb_a), 0);
      end
      if (t == 1) begin
        check_val("a_hs_c1", 32'(hs_a), 1);
        check_val("a_rgb_c1", 32'(rgb_a), 0);
      end
      if (t == 2)    check_val("a_rgb_first", 32'(rgb_a), 32'hFA5);
      if (t == 1025) check_val("a_rgb_last_vis", 32'(rgb_a), 32'hFA5);
      if (t == 1026) check_val("a_rgb_hblank", 32'(rgb_a), 0);
      if (t == 1049) check_val("a_hs_pre", 32'(hs_a), 1);
      if (t == 1050) check_val("a_hs_fall", 32'(hs_a), 0);
      if (t == 1185) check_val("a_hs_last", 32'(hs_a), 0);
      if (t == 1186) check_val("a_hs_rise", 32'(hs_a), 1);
      if (t == 1343) check_val("a_hs_width", 32'(hs_a_low), 136);
      if (t == 14783) begin
        check_val("a_wrap_hc_pre", 32'(bus_a.hc), 1343);
        check_val("a_wrap_vc_pre", 32'(bus_a.vc), 10);
      end
      if (t == 14784) begin
        check_val("a_wrap_hc", 32'(bus_a.hc), 0);
        check_val("a_wrap_vc", 32'(bus_a.vc), 11);
      end
      if (t == 14800) begin
        check_val("a_fs_count", 32'(fs_a_cnt), 1);
        check_val("a_vs_idle", 32'(vs_a), 1);
      end

      // Small instance, PIPE_LAT=3 (D=4)
      if (t == 3) begin
        check_val("b_hs_c3", 32'(hs_b), 1);
        check_val("b_rgb_c3", 32'(rgb_b), 0);
      end
      if (t == 71) check_val("b_hs_pre", 32'(hs_b), 1);
      if (t == 72) check_val("b_hs_fall", 32'(hs_b), 0);
      if (t == 79) check_val("b_hs_last", 32'(hs_b), 0);
      if (t == 80) check_val("b_hs_rise", 32'(hs_b), 1);
      if (t == 880) begin
        check_val("b_line_hc", 32'(bus_b.hc), 0);
        check_val("b_line_vc", 32'(bus_b.vc), 11);
      end
      if (t == 1443) check_val("b_rgb_blank_before", 32'(rgb_b), 0);
      if (t == 1444) check_val("b_rgb_x00_y12", 32'(rgb_b), 32'h010);
      if (t == 1497) check_val("b_rgb_x35_y12", 32'(rgb_b), 32'h310);
      if (t == 1507) check_val("b_rgb_x3f_y12", 32'(rgb_b), 32'h310);
      if (t == 1508) check_val("b_rgb_hblank", 32'(rgb_b), 0);
      if (t == 1977) check_val("b_rgb_vblank", 32'(rgb_b), 0);
      if (t == 2083) check_val("b_vs_pre", 32'(vs_b), 1);
      if (t == 2084) check_val("b_vs_fall", 32'(vs_b), 0);
      if (t == 2323) check_val("b_vs_last", 32'(vs_b), 0);
      if (t == 2324) check_val("b_vs_rise", 32'(vs_b), 1);
      if (t == 2559) begin
        check_val("b_vs_width", 32'(vs_b_low), 240);
        check_val("b_wrap_hc_pre", 32'(bus_b.hc), 79);
        check_val("b_wrap_vc_pre", 32'(bus_b.vc), 31);
      end
      if (t == 2560) begin
        check_val("b_wrap_hc", 32'(bus_b.hc), 0);
        check_val("b_wrap_vc", 32'(bus_b.vc), 0);
        check_val("b_wrap_fs", 32'(bus_b.frame_start), 1);
      end
      if (t == 4209) check_val("b_fs_count", 32'(fs_b_cnt), 2);
      if (t == 4210) begin
        check_val("b_mid_hc", 32'(bus_b.hc), 50);
        check_val("b_mid_vc", 32'(bus_b.vc), 20);
        rst_b_n = 1'b0;
      end
      if (t == 4211) begin
        check_val("b_mrst_hc", 32'(bus_b.hc), 0);
        check_val("b_mrst_vc", 32'(bus_b.vc), 0);
        check_val("b_mrst_fs", 32'(bus_b.frame_start), 1);
        check_val("b_mrst_hs", 32'(hs_b), 1);
        check_val("b_mrst_vs", 32'(vs_b), 1);
        check_val("b_mrst_rgb", 32'(rgb_b), 0);
        rst_b_n = 1'b1;
      end
      if (t == 4214) check_val("b_mrst_hs_hold", 32'(hs_b), 1);
      if (t == 4268) check_val("b_mrst_rgb_x35", 32'(rgb_b), 32'h300);
      if (t == 4282) check_val("b_mrst_hs_pre", 32'(hs_b), 1);
      if (t == 4283) check_val("b_mrst_hs_fall", 32'(hs_b), 0);

      // Upstream model for the small instance: pixel for coordinate issued 3 clocks ago.
      hist[t % 4] = {bus_b.hc[7:0], bus_b.vc[7:0]};
      if (t >= 3) bus_b.pixel_in = {hist[(t - 3) % 4], 8'h00};
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
